// File: rtl/stepdir_decoder.sv
// stepdir_decoder: receive-side step/dir decoder.
// Synchronizes asynchronous step/dir inputs, glitch-filters them (optional),
// counts accepted rising step edges up/down into a wrapping signed position,
// flags direction-to-step setup violations and measures the step period.
//
// Build option: define STEPDIR_DECODER_FILTER_EN to include the glitch filter.
// Without it the synchronized inputs are used directly and minpulse is unused.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   enable       count enable; accepted edges are discarded while low
//   step_in      external step (asynchronous)
//   dir_in       external direction (asynchronous), 1 = negative motion
//   minpulse     filter length: accept after minpulse+1 differing cycles
//   dirsetup     minimum cycles of stable filtered dir before a step edge
//   err_clear    synchronous clear of setup_err (a simultaneous set wins)
//   position     accumulated step count, two's complement, wraps
//   step_strobe  one-cycle pulse per counted step
//   dir_out      filtered direction
//   setup_err    sticky direction-setup violation flag
//   period       clk cycles between the last two counted steps, all-ones = stopped
module stepdir_decoder #(
  parameter int unsigned W = 32,
  parameter int unsigned T = 5,
  parameter int unsigned P = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         step_in,
  input  logic         dir_in,
  input  logic [T-1:0] minpulse,
  input  logic [T-1:0] dirsetup,
  input  logic         err_clear,
  output logic [W-1:0] position,
  output logic         step_strobe,
  output logic         dir_out,
  output logic         setup_err,
  output logic [P-1:0] period
);

  logic [1:0]   sync_step_q;
  logic [1:0]   sync_dir_q;
  logic         s_step;
  logic         s_dir;

  // Filtered view of the inputs, plus the value filtered dir takes next cycle.
  logic         filt_step;
  logic         filt_dir;
  logic         filt_dir_nxt;

  logic         step_prev_q;
  logic         dir_out_q;
  logic [T-1:0] dir_age_q,     dir_age_d;
  logic [W-1:0] position_q,    position_d;
  logic         step_strobe_q, step_strobe_d;
  logic         setup_err_q,   setup_err_d;
  logic [P-1:0] period_q,      period_d;
  logic [P-1:0] pcnt_q,        pcnt_d;
  logic         rise;
  logic         count;

  // Two-flop synchronizers, always running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_step_q <= 2'b00;
      sync_dir_q  <= 2'b00;
    end else begin
      sync_step_q <= {sync_step_q[0], step_in};
      sync_dir_q  <= {sync_dir_q[0], dir_in};
    end
  end

  assign s_step = sync_step_q[1];
  assign s_dir  = sync_dir_q[1];

`ifdef STEPDIR_DECODER_FILTER_EN
  logic         filt_step_q, filt_step_d;
  logic         filt_dir_q,  filt_dir_d;
  logic [T-1:0] step_cnt_q,  step_cnt_d;
  logic [T-1:0] dir_cnt_q,   dir_cnt_d;

  // Per-signal glitch filter: accept a new level after minpulse+1 differing cycles.
  always_comb begin
    filt_step_d = filt_step_q;
    step_cnt_d  = '0;
    filt_dir_d  = filt_dir_q;
    dir_cnt_d   = '0;
    if (s_step != filt_step_q) begin
      if (step_cnt_q == minpulse) begin
        filt_step_d = s_step;
      end else begin
        step_cnt_d = step_cnt_q + T'(1);
      end
    end
    if (s_dir != filt_dir_q) begin
      if (dir_cnt_q == minpulse) begin
        filt_dir_d = s_dir;
      end else begin
        dir_cnt_d = dir_cnt_q + T'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_step_q <= 1'b0;
      filt_dir_q  <= 1'b0;
      step_cnt_q  <= '0;
      dir_cnt_q   <= '0;
    end else begin
      filt_step_q <= filt_step_d;
      filt_dir_q  <= filt_dir_d;
      step_cnt_q  <= step_cnt_d;
      dir_cnt_q   <= dir_cnt_d;
    end
  end

  assign filt_step    = filt_step_q;
  assign filt_dir     = filt_dir_q;
  assign filt_dir_nxt = filt_dir_d;
`else
  logic unused_minpulse;

  assign unused_minpulse = ^minpulse;
  assign filt_step       = s_step;
  assign filt_dir        = s_dir;
  assign filt_dir_nxt    = sync_dir_q[0];
`endif

  // dir_out lags filtered dir by one cycle, so a step edge coinciding with a
  // dir change counts in the old direction while dir_age already reads 0.
  assign rise  = filt_step & ~step_prev_q;
  assign count = rise & enable;

  // Next-state for counters, flags and period measurement.
  always_comb begin
    position_d    = position_q;
    step_strobe_d = 1'b0;
    setup_err_d   = setup_err_q;
    period_d      = period_q;
    pcnt_d        = pcnt_q;
    dir_age_d     = dir_age_q;

    if (filt_dir_nxt != filt_dir) begin
      dir_age_d = '0;
    end else if (dir_age_q != '1) begin
      dir_age_d = dir_age_q + T'(1);
    end

    if (err_clear) begin
      setup_err_d = 1'b0;
    end

    if (count) begin
      position_d    = dir_out_q ? (position_q - W'(1)) : (position_q + W'(1));
      step_strobe_d = 1'b1;
      if (dir_age_q < dirsetup) begin
        setup_err_d = 1'b1;
      end
      period_d = pcnt_q;
      pcnt_d   = P'(1);
    end else begin
      if (pcnt_q != '1) begin
        pcnt_d = pcnt_q + P'(1);
      end
      // Saturated counter means no step for a full range: report stopped.
      if (pcnt_d == '1) begin
        period_d = '1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_prev_q   <= 1'b0;
      dir_out_q     <= 1'b0;
      dir_age_q     <= '1;
      position_q    <= '0;
      step_strobe_q <= 1'b0;
      setup_err_q   <= 1'b0;
      period_q      <= '1;
      pcnt_q        <= '1;
    end else begin
      step_prev_q   <= filt_step;
      dir_out_q     <= filt_dir;
      dir_age_q     <= dir_age_d;
      position_q    <= position_d;
      step_strobe_q <= step_strobe_d;
      setup_err_q   <= setup_err_d;
      period_q      <= period_d;
      pcnt_q        <= pcnt_d;
    end
  end

  assign position    = position_q;
  assign step_strobe = step_strobe_q;
  assign dir_out     = dir_out_q;
  assign setup_err   = setup_err_q;
  assign period      = period_q;

endmodule

// File: tb/tb_stepdir_decoder.sv
// Directed self-checking bench for stepdir_decoder (W=8, T=5, P=16).
module tb_stepdir_decoder;

  localparam int unsigned W = 8;
  localparam int unsigned T = 5;
  localparam int unsigned P = 16;
`ifdef STEPDIR_DECODER_FILTER_EN
  localparam int FILT = 1;
`else
  localparam int FILT = 0;
`endif

  logic         clk;
  logic         reset;
  logic         enable;
  logic         step_in;
  logic         dir_in;
  logic [T-1:0] minpulse;
  logic [T-1:0] dirsetup;
  logic         err_clear;
  logic [W-1:0] position;
  logic         step_strobe;
  logic         dir_out;
  logic         setup_err;
  logic [P-1:0] period;

  int checks;
  int errors;
  int strobes;

  stepdir_decoder #(.W(W), .T(T), .P(P)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .step_in     (step_in),
    .dir_in      (dir_in),
    .minpulse    (minpulse),
    .dirsetup    (dirsetup),
    .err_clear   (err_clear),
    .position    (position),
    .step_strobe (step_strobe),
    .dir_out     (dir_out),
    .setup_err   (setup_err),
    .period      (period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample 1 time unit after the edge and tally strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    if (step_strobe === 1'b1) strobes++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input int hi, input int lo);
    step_in = 1'b1;
    ticks(hi);
    step_in = 1'b0;
    ticks(lo);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ticks(3);
    checks++; if (position !== 8'h00) begin errors++; $display("FAIL reset_position got %h exp 00", position); end
    checks++; if (step_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0", step_strobe); end
    checks++; if (dir_out !== 1'b0) begin errors++; $display("FAIL reset_dir_out got %b exp 0", dir_out); end
    checks++; if (setup_err !== 1'b0) begin errors++; $display("FAIL reset_setup_err got %b exp 0", setup_err); end
    checks++; if (period !== 16'hFFFF) begin errors++; $display("FAIL reset_period got %h exp ffff", period); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_count();
    int s0;
    int first;
    int exp_first;
    apply_reset();
    minpulse = 5'd2;
    dirsetup = 5'd0;
    dir_in   = 1'b0;
    enable   = 1'b1;
    ticks(2);
    s0    = strobes;
    first = 0;
    exp_first = (FILT != 0) ? 6 : 3;
    step_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (step_strobe === 1'b1 && first == 0) first = i;
      if (i == 4) step_in = 1'b0;
    end
    for (int p = 0; p < 9; p++) pulse(4, 4);
    ticks(10);
    checks++; if (first !== exp_first) begin errors++; $display("FAIL count_latency got %0d exp %0d", first, exp_first); end
    checks++; if ((strobes - s0) !== 10) begin errors++; $display("FAIL count_strobes got %0d exp 10", strobes - s0); end
    checks++; if (position !== 8'd10) begin errors++; $display("FAIL count_position got %h exp 0a", position); end
  endtask

  task automatic test_glitch();
    int s0;
    int exp_n;
    logic [W-1:0] p0;
    minpulse = 5'd3;
    exp_n = (FILT != 0) ? 0 : 1;
    p0 = position;
    s0 = strobes;
    step_in = 1'b1;
    ticks(3);
    step_in = 1'b0;
    ticks(10);
    checks++; if ((strobes - s0) !== exp_n) begin errors++; $display("FAIL glitch_strobes got %0d exp %0d", strobes - s0, exp_n); end
    checks++; if (position !== p0 + W'(exp_n)) begin errors++; $display("FAIL glitch_position got %h exp %h", position, p0 + W'(exp_n)); end
    p0 = position;
    s0 = strobes;
    pulse(5, 10);
    checks++; if ((strobes - s0) !== 1) begin errors++; $display("FAIL long_pulse_strobes got %0d exp 1", strobes - s0); end
    checks++; if (position !== p0 + 8'd1) begin errors++; $display("FAIL long_pulse_position got %h exp %h", position, p0 + 8'd1); end
  endtask

  task automatic test_setup();
    logic [W-1:0] p0;
    minpulse  = 5'd1;
    dirsetup  = 5'd4;
    err_clear = 1'b0;
    p0 = position;
    // dir changes only 2 cycles ahead of the step edge
    dir_in = 1'b1;
    ticks(2);
    pulse(4, 8);
    checks++; if (setup_err !== 1'b1) begin errors++; $display("FAIL setup_short_err got %b exp 1", setup_err); end
    checks++; if (position !== p0 - 8'd1) begin errors++; $display("FAIL setup_short_position got %h exp %h", position, p0 - 8'd1); end
    checks++; if (dir_out !== 1'b1) begin errors++; $display("FAIL setup_dir_out got %b exp 1", dir_out); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checks++; if (setup_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", setup_err); end
    // 6-cycle margin: no violation
    dir_in = 1'b0;
    ticks(6);
    pulse(4, 8);
    checks++; if (setup_err !== 1'b0) begin errors++; $display("FAIL setup_margin6_err got %b exp 0", setup_err); end
    checks++; if (position !== p0) begin errors++; $display("FAIL setup_margin6_position got %h exp %h", position, p0); end
    // exactly dirsetup cycles: allowed
    dir_in = 1'b1;
    ticks(4);
    pulse(4, 8);
    checks++; if (setup_err !== 1'b0) begin errors++; $display("FAIL setup_margin4_err got %b exp 0", setup_err); end
    checks++; if (position !== p0 - 8'd1) begin errors++; $display("FAIL setup_margin4_position got %h exp %h", position, p0 - 8'd1); end
    // one cycle short: violation
    dir_in = 1'b0;
    ticks(3);
    pulse(4, 8);
    checks++; if (setup_err !== 1'b1) begin errors++; $display("FAIL setup_margin3_err got %b exp 1", setup_err); end
    checks++; if (position !== p0) begin errors++; $display("FAIL setup_margin3_position got %h exp %h", position, p0); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] p0;
    dirsetup = 5'd4;
    ticks(4);
    p0 = position;
    // dir and step change together: counts in the old (positive) direction
    dir_in  = 1'b1;
    step_in = 1'b1;
    ticks(4);
    step_in = 1'b0;
    ticks(8);
    checks++; if (position !== p0 + 8'd1) begin errors++; $display("FAIL simul_position got %h exp %h", position, p0 + 8'd1); end
    checks++; if (setup_err !== 1'b1) begin errors++; $display("FAIL simul_err got %b exp 1", setup_err); end
    checks++; if (dir_out !== 1'b1) begin errors++; $display("FAIL simul_dir_out got %b exp 1", dir_out); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    dir_in = 1'b0;
    ticks(8);
    checks++; if (setup_err !== 1'b0) begin errors++; $display("FAIL simul_clear got %b exp 0", setup_err); end
  endtask

  task automatic test_wrap();
    apply_reset();
    minpulse = 5'd0;
    dirsetup = 5'd0;
    dir_in   = 1'b0;
    ticks(2);
    for (int i = 0; i < 127; i++) pulse(2, 2);
    checks++; if (position !== 8'h7F) begin errors++; $display("FAIL wrap_127 got %h exp 7f", position); end
    pulse(2, 2);
    checks++; if (position !== 8'h80) begin errors++; $display("FAIL wrap_pos_to_neg got %h exp 80", position); end
    apply_reset();
    dir_in = 1'b1;
    ticks(4);
    pulse(2, 2);
    checks++; if (position !== 8'hFF) begin errors++; $display("FAIL wrap_zero_down got %h exp ff", position); end
    checks++; if (dir_out !== 1'b1) begin errors++; $display("FAIL wrap_dir_out got %b exp 1", dir_out); end
    dir_in = 1'b0;
    ticks(4);
  endtask

  task automatic test_period();
    int s0;
    apply_reset();
    minpulse = 5'd0;
    dirsetup = 5'd0;
    dir_in   = 1'b0;
    enable   = 1'b1;
    ticks(2);
    for (int i = 0; i < 3; i++) pulse(4, 96);
    checks++; if (period !== 16'd100) begin errors++; $display("FAIL period_100 got %0d exp 100", period); end
    checks++; if (position !== 8'd3) begin errors++; $display("FAIL period_position got %h exp 03", position); end
    enable = 1'b0;
    s0 = strobes;
    pulse(4, 96);
    checks++; if (period !== 16'd100) begin errors++; $display("FAIL disabled_period got %0d exp 100", period); end
    checks++; if (position !== 8'd3) begin errors++; $display("FAIL disabled_position got %h exp 03", position); end
    checks++; if ((strobes - s0) !== 0) begin errors++; $display("FAIL disabled_strobes got %0d exp 0", strobes - s0); end
    enable = 1'b1;
    pulse(4, 96);
    checks++; if (period !== 16'd200) begin errors++; $display("FAIL period_after_skip got %0d exp 200", period); end
    ticks(65540);
    checks++; if (period !== 16'hFFFF) begin errors++; $display("FAIL period_stopped got %h exp ffff", period); end
    pulse(4, 96);
    checks++; if (period !== 16'hFFFF) begin errors++; $display("FAIL period_first_after_stop got %h exp ffff", period); end
    pulse(4, 96);
    checks++; if (period !== 16'd100) begin errors++; $display("FAIL period_resume got %0d exp 100", period); end
    checks++; if (position !== 8'd6) begin errors++; $display("FAIL period_final_position got %h exp 06", position); end
  endtask

  task automatic test_reset_mid();
    int s0;
    int exp_n;
    apply_reset();
    minpulse = 5'd3;
    dirsetup = 5'd0;
    dir_in   = 1'b1;
    ticks(8);
    for (int i = 0; i < 5; i++) pulse(5, 5);
    checks++; if (position !== 8'hFB) begin errors++; $display("FAIL mid_pre_position got %h exp fb", position); end
    step_in = 1'b1;
    ticks(2);
    #3 reset = 1'b1;
    #1;
    checks++; if (position !== 8'h00) begin errors++; $display("FAIL mid_async_position got %h exp 00", position); end
    checks++; if (step_strobe !== 1'b0) begin errors++; $display("FAIL mid_async_strobe got %b exp 0", step_strobe); end
    checks++; if (dir_out !== 1'b0) begin errors++; $display("FAIL mid_async_dir_out got %b exp 0", dir_out); end
    checks++; if (period !== 16'hFFFF) begin errors++; $display("FAIL mid_async_period got %h exp ffff", period); end
    dir_in = 1'b0;
    tick();
    s0 = strobes;
    reset = 1'b0;
    tick();
    step_in = 1'b0;
    ticks(10);
    exp_n = (FILT != 0) ? 0 : 1;
    checks++; if ((strobes - s0) !== exp_n) begin errors++; $display("FAIL mid_straddle_strobes got %0d exp %0d", strobes - s0, exp_n); end
    checks++; if (position !== W'(exp_n)) begin errors++; $display("FAIL mid_straddle_position got %h exp %h", position, W'(exp_n)); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    strobes   = 0;
    reset     = 1'b1;
    enable    = 1'b1;
    step_in   = 1'b0;
    dir_in    = 1'b0;
    minpulse  = 5'd0;
    dirsetup  = 5'd0;
    err_clear = 1'b0;
    test_reset();
    test_count();
    test_glitch();
    test_setup();
    test_simultaneous();
    test_wrap();
    test_period();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stepdir_decoder.md
Name: stepdir_decoder

Overview:
- Receive-side counterpart of the step/dir generator: decodes an external step/dir pulse stream into a signed position count.
- Captures asynchronous step_in/dir_in, synchronizes and glitch-filters them, counts accepted step rising edges up or down by direction, and checks direction-to-step setup timing.
- Measures the interval between steps.
- Used for loopback verification of the step generator and for reading external step/dir sources such as handwheels and a second controller.

Parameters:
W, 32, position counter width (two's complement, wraps)
T, 5, width of minpulse/dirsetup thresholds and dir-age counter
P, 16, width of step period counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  count enable; when low, accepted edges are discarded
step_in  input  1  external step, asynchronous
dir_in  input  1  external direction, asynchronous; 1 = negative motion (same sense as generator velocity sign bit)
minpulse  input  T  filter length: input must differ from filtered value for minpulse+1 consecutive cycles to be accepted
dirsetup  input  T  minimum cycles filtered dir must be stable before an accepted step edge
err_clear  input  1  synchronous clear of setup_err
position  output  W  accumulated step count
step_strobe  output  1  one-cycle pulse per counted step
dir_out  output  1  filtered direction
setup_err  output  1  sticky direction-setup violation flag
period  output  P  clk cycles between the last two counted steps; all-ones = stopped/unknown

Behaviour:
- Reset (async, active-high) values:
  - position=0, step_strobe=0, dir_out=0, setup_err=0, period=all-ones.
  - Synchronizer flops, filter state and filter counters = 0; dir_age = 2^T-1; period counter = all-ones.
- Synchronizer: 2 flops per input (s_step, s_dir). Runs regardless of enable.
- Glitch filter, per signal, counter c:
  - If s == filt: c <= 0.
  - Else if c == minpulse: filt <= s, c <= 0.
  - Else: c <= c+1.
  - With minpulse=0, filt follows s one cycle late. A pulse shorter than minpulse+1 cycles at the sync output never changes filt.
- dir_out = filtered dir.
- dir_age:
  - Resets to 0 on the cycle filtered dir changes.
  - Otherwise increments, saturating at 2^T-1.
- Edge detect: rise = filt_step & ~filt_step_q.
- On a cycle where rise=1 and enable=1, on the next clock edge:
  - position <= position-1 if dir_out=1, else position+1; modulo 2^W, no saturation, no flag.
  - step_strobe <= 1 for exactly one cycle.
  - If dir_age < dirsetup: setup_err <= 1. dirsetup=0 never flags.
  - period <= period counter value; period counter <= 1.
- If rise=1 and enable=0: the edge is discarded. No position, strobe, error or period update.
- Latency: with step_in first sampled high at clock k and held, position/step_strobe change at clock k+minpulse+3.
- Filtered falling step edges are ignored.
- Period counter:
  - Increments every cycle, saturating at all-ones.
  - On reaching all-ones: period <= all-ones (stopped indication).
- setup_err:
  - err_clear=1 clears it.
  - Simultaneous set and clear: set wins.
- Simultaneous dir change and step edge in the same filtered cycle: dir_age=0, so the step counts in the old direction (dir_out not yet updated) and the setup violation flags if dirsetup>0.
- Change of minpulse/dirsetup mid-operation takes effect next cycle. A filter counter already above a newly lowered minpulse continues to wrap at 2^T before matching; this is accepted.
- Reset mid-operation clears everything immediately, including in-flight filter state; no strobe is produced.

Optional Feature:
- Macro: STEPDIR_DECODER_FILTER_EN.
- Defined: glitch filter as above.
- Undefined:
  - Filter logic is removed; filt = s directly, minpulse is ignored (port kept, unused).
  - Latency becomes k+2.

Test Plan:
1. minpulse=2, dir_in=0 held, 10 step_in pulses 4 high/4 low cycles -> position=10, 10 step_strobe pulses; first strobe at k+5.
2. minpulse=3, step_in glitch high 3 cycles -> no strobe, position unchanged; then high 5 cycles -> one count.
3. dirsetup=4: dir_in toggled 2 cycles (filtered) before step edge -> setup_err=1, position decremented. err_clear -> setup_err=0. Repeat with 6-cycle margin -> no error.
4. W=8, position driven to 127 by steps, one more +step -> -128 (8'h80); dir=1 from 0 -> 8'hFF.
5. Steps every 100 cycles -> period=100 after the second step; no steps for 2^P cycles -> period=16'hFFFF. enable=0 during a step -> step not counted, period unchanged.
6. Assert reset mid-pulse after 5 counts -> all outputs at reset values asynchronously; the pulse straddling reset release does not count if filt had not yet accepted it.
